// File: rtl/regfile_wp_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_NUM / REG_ADDR_W : register file geometry (32 x 32)
//   REG_ADDR_ZERO        : hard-wired zero register $0
//   ZERO_WORD            : idle value of the write data bus
//   arbState_t           : NORMAL / STARVE arbitration state
//   addrOneHot()         : register address -> one-hot register mask
package regfile_wp_arbiter_pkg;

   localparam int          REG_NUM       = 32;
   localparam int          REG_ADDR_W    = 5;
   localparam logic [4:0]  REG_ADDR_ZERO = 5'd0;
   localparam logic [31:0] ZERO_WORD     = 32'd0;

   typedef enum logic {
      NORMAL = 1'b0,
      STARVE = 1'b1
   } arbState_t;

   function automatic logic [REG_NUM-1:0] addrOneHot(input logic [REG_ADDR_W-1:0] addr);
      logic [REG_NUM-1:0] mask;
      mask       = '0;
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/regfile_wp_arbiter_scoreboard.sv
// Busy-register scoreboard for outstanding multi-cycle results.
//   clk, rst         : clock, synchronous active-high reset
//   setEn/setAddr    : a multi-cycle op was issued to setAddr
//   clrEn/clrAddr    : the multi-cycle result for clrAddr was written
//   rs*/rt*/dst*     : decode-stage operand and destination lookups
//   hazard           : decode touches a register that is still pending
module regfile_wp_arbiter_scoreboard
   import regfile_wp_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  setEn,
   input  logic [REG_ADDR_W-1:0] setAddr,
   input  logic                  clrEn,
   input  logic [REG_ADDR_W-1:0] clrAddr,
   input  logic [REG_ADDR_W-1:0] rsAddr,
   input  logic                  rsUsed,
   input  logic [REG_ADDR_W-1:0] rtAddr,
   input  logic                  rtUsed,
   input  logic                  dstWe,
   input  logic [REG_ADDR_W-1:0] dstAddr,
   output logic                  hazard
);

   logic [REG_NUM-1:0] busyQ;
   logic [REG_NUM-1:0] busyNext;
   logic [REG_NUM-1:0] setMask;
   logic [REG_NUM-1:0] clrMask;

   always_comb begin
      setMask = '0;
      clrMask = '0;
      if (setEn && setAddr != REG_ADDR_ZERO) setMask = addrOneHot(setAddr);
      if (clrEn) clrMask = addrOneHot(clrAddr);
      // clear first, then set: an issue to the register being retired wins
      busyNext    = (busyQ & ~clrMask) | setMask;
      busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busyQ <= '0;
      else     busyQ <= busyNext;
   end

   assign hazard = (rsUsed && busyQ[rsAddr]) ||
                   (rtUsed && busyQ[rtAddr]) ||
                   (dstWe  && busyQ[dstAddr]);

endmodule

// File: rtl/regfile_wp_arbiter.sv
// Register-file write-port arbiter: shares the single write port between the
// WB stage and the multi-cycle (mul/div) result path, bounds how long a
// multi-cycle result can be refused, and generates the decode stall.
//   clk, rst                   : clock, synchronous active-high reset
//   wb_we/wb_addr/wb_data      : WB stage write request
//   mc_valid/mc_addr/mc_data   : multi-cycle result, mc_ready accepts it
//   mc_issue/mc_issue_addr     : decode issues a multi-cycle op
//   dec_*                      : decode operand/destination hazard lookup
//   dec_stall                  : stall IF/ID
//   wb_hold                    : registered; freeze MEM/WB for one cycle
//   rf_we/rf_waddr/rf_wdata    : register file write port
//
// state  | meaning
// NORMAL | WB has priority; consecutive mc refusals are counted
// STARVE | one cycle: mc owns the port, WB is held off via wb_hold
module regfile_wp_arbiter
   import regfile_wp_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        mc_valid,
   input  logic [4:0]  mc_addr,
   input  logic [31:0] mc_data,
   output logic        mc_ready,
   input  logic        mc_issue,
   input  logic [4:0]  mc_issue_addr,
   input  logic [4:0]  dec_rs_addr,
   input  logic        dec_rs_used,
   input  logic [4:0]  dec_rt_addr,
   input  logic        dec_rt_used,
   input  logic        dec_we,
   input  logic [4:0]  dec_dst_addr,
   output logic        dec_stall,
   output logic        wb_hold,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);

   arbState_t        state;
   arbState_t        stateNext;
   logic [CNT_W-1:0] waitCnt;
   logic [CNT_W-1:0] waitCntNext;
   logic             starve;
   logic             wbEff;
   logic             wbGrant;
   logic             mcHandshake;
   logic             mcRefused;
   logic             sbHazard;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= NORMAL;
         waitCnt <= '0;
         wb_hold <= 1'b0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
         wb_hold <= (stateNext == STARVE);
      end
   end

   always_comb begin
      stateNext   = state;
      waitCntNext = '0;
      if (state == STARVE) begin
         stateNext = NORMAL;
      end else if (mcRefused) begin
         if (waitCnt == CNT_W'(MAX_WAIT - 1)) stateNext = STARVE;
         else                                 waitCntNext = waitCnt + CNT_W'(1);
      end
   end

   always_comb begin
      starve      = (state == STARVE);
      wbEff       = wb_we && (wb_addr != REG_ADDR_ZERO);
      wbGrant     = !starve && wbEff;
      mc_ready    = mc_valid && !wbGrant;
      mcHandshake = mc_valid && mc_ready;
      mcRefused   = mc_valid && !mc_ready;
      rf_we       = 1'b0;
      rf_waddr    = REG_ADDR_ZERO;
      rf_wdata    = ZERO_WORD;
      if (wbGrant) begin
         rf_we    = 1'b1;
         rf_waddr = wb_addr;
         rf_wdata = wb_data;
      end else if (mcHandshake) begin
         // a result for $0 still completes the handshake but never writes
         rf_we    = (mc_addr != REG_ADDR_ZERO);
         rf_waddr = mc_addr;
         rf_wdata = mc_data;
      end
   end

   regfile_wp_arbiter_scoreboard uScoreboard (
      .clk     (clk),
      .rst     (rst),
      .setEn   (mc_issue),
      .setAddr (mc_issue_addr),
      .clrEn   (mcHandshake),
      .clrAddr (mc_addr),
      .rsAddr  (dec_rs_addr),
      .rsUsed  (dec_rs_used),
      .rtAddr  (dec_rt_addr),
      .rtUsed  (dec_rt_used),
      .dstWe   (dec_we),
      .dstAddr (dec_dst_addr),
      .hazard  (sbHazard)
   );

   assign dec_stall = sbHazard || wb_hold;

endmodule

// File: tb/tb_regfile_wp_arbiter.sv
// Self-checking bench for regfile_wp_arbiter: directed stimulus, a
// behavioural model compared every cycle, plus hand-computed pinned values.
module tb_regfile_wp_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        mc_valid;
   logic [4:0]  mc_addr;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic        mc_issue;
   logic [4:0]  mc_issue_addr;
   logic [4:0]  dec_rs_addr;
   logic        dec_rs_used;
   logic [4:0]  dec_rt_addr;
   logic        dec_rt_used;
   logic        dec_we;
   logic [4:0]  dec_dst_addr;
   logic        dec_stall;
   logic        wb_hold;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   always #5 clk = ~clk;

   regfile_wp_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
      .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr),
      .dec_rs_addr(dec_rs_addr), .dec_rs_used(dec_rs_used),
      .dec_rt_addr(dec_rt_addr), .dec_rt_used(dec_rt_used),
      .dec_we(dec_we), .dec_dst_addr(dec_dst_addr),
      .dec_stall(dec_stall), .wb_hold(wb_hold),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   int checks   = 0;
   int failures = 0;
   int cycleCnt = 0;

   // model state: pending registers and the length of the current refusal run
   bit busyM [32];
   int refusedM = 0;

   // hand-computed expectation pinned to one cycle
   int          pinCycle = -1;
   string       pinName  = "";
   logic        pinWe, pinReady, pinHold, pinStall;
   logic [4:0]  pinWaddr;
   logic [31:0] pinWdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cycleCnt, act, exp);
      end
   endtask

   always @(negedge clk) begin : compareProc
      logic        starveM, wbEffM, readyM, hsM, weM, stallM;
      logic [4:0]  waM;
      logic [31:0] wdM;
      // a result that has already been refused MAX_WAIT times in a row wins
      starveM = (refusedM >= MAX_WAIT);
      wbEffM  = wb_we && (wb_addr != 5'd0);
      readyM  = mc_valid && (starveM || !wbEffM);
      hsM     = mc_valid && readyM;
      weM = 1'b0; waM = 5'd0; wdM = 32'd0;
      if (!starveM && wbEffM) begin
         weM = 1'b1; waM = wb_addr; wdM = wb_data;
      end else if (hsM) begin
         weM = (mc_addr != 5'd0); waM = mc_addr; wdM = mc_data;
      end
      stallM = (dec_rs_used && busyM[dec_rs_addr]) ||
               (dec_rt_used && busyM[dec_rt_addr]) ||
               (dec_we && busyM[dec_dst_addr]) || starveM;
      if (!rst) begin
         chk("model.rf_we",     32'(rf_we),     32'(weM));
         chk("model.rf_waddr",  32'(rf_waddr),  32'(waM));
         chk("model.rf_wdata",  rf_wdata,       wdM);
         chk("model.mc_ready",  32'(mc_ready),  32'(readyM));
         chk("model.dec_stall", 32'(dec_stall), 32'(stallM));
         chk("model.wb_hold",   32'(wb_hold),   32'(starveM));
      end
      if (pinCycle == cycleCnt) begin
         chk({pinName, ".rf_we"},     32'(rf_we),     32'(pinWe));
         chk({pinName, ".rf_waddr"},  32'(rf_waddr),  32'(pinWaddr));
         chk({pinName, ".rf_wdata"},  rf_wdata,       pinWdata);
         chk({pinName, ".mc_ready"},  32'(mc_ready),  32'(pinReady));
         chk({pinName, ".wb_hold"},   32'(wb_hold),   32'(pinHold));
         chk({pinName, ".dec_stall"}, 32'(dec_stall), 32'(pinStall));
      end
      if (rst) begin
         for (int i = 0; i < 32; i++) busyM[i] = 1'b0;
         refusedM = 0;
      end else begin
         if (hsM) busyM[mc_addr] = 1'b0;
         if (mc_issue && mc_issue_addr != 5'd0) busyM[mc_issue_addr] = 1'b1;
         if (!starveM && mc_valid && !readyM) refusedM++;
         else                                 refusedM = 0;
      end
      cycleCnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setIdle();
      wb_we = 0; wb_addr = 0; wb_data = 0;
      mc_valid = 0; mc_addr = 0; mc_data = 0;
      mc_issue = 0; mc_issue_addr = 0;
      dec_rs_addr = 0; dec_rs_used = 0; dec_rt_addr = 0; dec_rt_used = 0;
      dec_we = 0; dec_dst_addr = 0;
   endtask

   task automatic pin(input string n, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic rdy, input logic hold,
                      input logic stall);
      pinName = n; pinWe = we; pinWaddr = wa; pinWdata = wd;
      pinReady = rdy; pinHold = hold; pinStall = stall;
      pinCycle = cycleCnt;
   endtask

   task automatic driveWbMc(input logic [4:0] wa, input logic [31:0] wd,
                            input logic [4:0] ma, input logic [31:0] md);
      wb_we = 1; wb_addr = wa; wb_data = wd;
      mc_valid = 1; mc_addr = ma; mc_data = md;
   endtask

   initial begin
      rst = 1;
      setIdle();
      tick(); tick();
      // 1: reset state, then probe every busy bit
      rst = 0;
      pin("reset", 0, 5'd0, 32'h0, 0, 0, 0);
      for (int a = 0; a < 32; a++) begin
         tick(); dec_rs_used = 1; dec_rs_addr = 5'(a);
      end
      tick(); setIdle();

      // 2: WB wins a conflict, mc goes next cycle
      tick(); driveWbMc(5'd5, 32'h11, 5'd7, 32'h22);
      pin("conflict_wb", 1, 5'd5, 32'h11, 0, 0, 0);
      tick(); wb_we = 0;
      pin("conflict_mc", 1, 5'd7, 32'h22, 1, 0, 0);
      tick(); setIdle();

      // 3: starvation bound
      for (int c = 1; c <= 4; c++) begin
         tick(); driveWbMc(5'd3, 32'h33, 5'd9, 32'h99);
         pin($sformatf("starve_refuse%0d", c), 1, 5'd3, 32'h33, 0, 0, 0);
      end
      tick();
      pin("starve_grant", 1, 5'd9, 32'h99, 1, 1, 1);
      tick(); mc_valid = 0;
      pin("starve_after", 1, 5'd3, 32'h33, 0, 0, 0);
      tick(); setIdle();

      // 4: scoreboard on register 8
      tick(); mc_issue = 1; mc_issue_addr = 5'd8;
      pin("sb_issue", 0, 5'd0, 32'h0, 0, 0, 0);
      tick(); mc_issue = 0; dec_rs_used = 1; dec_rs_addr = 5'd8;
      pin("sb_rs", 0, 5'd0, 32'h0, 0, 0, 1);
      tick(); dec_rs_used = 0; dec_we = 1; dec_dst_addr = 5'd8;
      pin("sb_waw", 0, 5'd0, 32'h0, 0, 0, 1);
      tick(); dec_we = 0; dec_rt_used = 1; dec_rt_addr = 5'd8;
      pin("sb_rt", 0, 5'd0, 32'h0, 0, 0, 1);
      tick(); mc_valid = 1; mc_addr = 5'd8; mc_data = 32'h88;
      pin("sb_handshake", 1, 5'd8, 32'h88, 1, 0, 1);
      tick(); mc_valid = 0;
      pin("sb_cleared", 0, 5'd0, 32'h0, 0, 0, 0);
      tick(); setIdle();

      // 5: register $0
      tick(); mc_issue = 1; mc_issue_addr = 5'd0;
      tick(); mc_issue = 0; dec_rs_used = 1; dec_rs_addr = 5'd0;
      pin("zero_busy", 0, 5'd0, 32'h0, 0, 0, 0);
      tick(); dec_rs_used = 0; driveWbMc(5'd0, 32'h55, 5'd6, 32'h66);
      pin("zero_wb", 1, 5'd6, 32'h66, 1, 0, 0);
      tick(); wb_we = 0; mc_addr = 5'd0; mc_data = 32'h77;
      pin("zero_mc", 0, 5'd0, 32'h77, 1, 0, 0);
      tick(); setIdle();

      // 6a: same-address set and clear, set wins
      tick(); mc_issue = 1; mc_issue_addr = 5'd4;
      mc_valid = 1; mc_addr = 5'd4; mc_data = 32'h44;
      pin("setclr_hs", 1, 5'd4, 32'h44, 1, 0, 0);
      tick(); setIdle(); dec_rs_used = 1; dec_rs_addr = 5'd4;
      pin("setclr_busy", 0, 5'd0, 32'h0, 0, 0, 1);
      tick(); dec_rs_used = 0; mc_valid = 1; mc_addr = 5'd4; mc_data = 32'h45;
      tick(); setIdle();

      // 6b: reset in the STARVE cycle
      tick(); driveWbMc(5'd3, 32'h33, 5'd9, 32'h99); mc_issue = 1; mc_issue_addr = 5'd12;
      tick(); mc_issue = 0;
      tick(); tick();
      tick(); rst = 1;
      pin("rst_starve", 1, 5'd9, 32'h99, 1, 1, 1);
      tick(); rst = 0; dec_rs_used = 1; dec_rs_addr = 5'd12;
      pin("rst_after", 1, 5'd3, 32'h33, 0, 0, 0);
      tick(); setIdle();
      tick(); tick();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
